// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter family.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int SYS_CLK_HZ           = 50_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;

  localparam int PARITY_EVEN      = 0;
  localparam int PARITY_SENSE_ODD = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-rate divider: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_restart,
  output logic [$clog2(CLKS_PER_BIT)-1:0] o_count,
  output logic                            o_bit_tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit counter, forced to zero while restart is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_count    = r_cnt;
  assign o_bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and registered serial output.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = PARITY_EVEN
) (
  input  logic                 tick,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 TxD,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  generate
    if ((DATA_BITS < 5) || (DATA_BITS > 9) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) ||
        ((PARITY_ODD != PARITY_EVEN) && (PARITY_ODD != PARITY_SENSE_ODD))) begin : g_bad_params
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_txd;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic [CNT_W-1:0] w_count;
  logic             w_bit_tick;
  logic             w_accept;
  logic             w_last_stop;
  logic             w_pre_tick;

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD == PARITY_SENSE_ODD);
  endfunction
`endif

  assign w_accept    = valid & r_ready;
  assign w_last_stop = (r_bit_cnt == LAST_STOP);
  assign w_pre_tick  = (w_count == PRE_LAST);

  // Every non-idle state entry coincides with a counter wrap, so only IDLE needs the hold.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk      (tick),
    .i_rst_n    (rst),
    .i_restart  (r_state == IDLE),
    .o_count    (w_count),
    .o_bit_tick (w_bit_tick)
  );

  // Frame sequencer, shift register and all registered outputs.
  always_ff @(posedge tick or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shift   <= {DATA_BITS{1'b0}};
      r_bit_cnt <= {BIT_W{1'b0}};
      r_txd     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= START;
            r_shift   <= data;
            r_bit_cnt <= {BIT_W{1'b0}};
            r_txd     <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= f_parity(data);
`endif
          end else begin
            r_txd   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        START: begin
          if (w_bit_tick) begin
            r_state   <= DATA;
            r_bit_cnt <= {BIT_W{1'b0}};
            r_txd     <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
              r_state   <= PARITY;
              r_txd     <= r_parity;
`else
              r_state   <= STOP;
              r_txd     <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_txd     <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_tick) begin
            r_state   <= STOP;
            r_bit_cnt <= {BIT_W{1'b0}};
            r_txd     <= 1'b1;
          end
        end
`endif
        STOP: begin
          // done/ready are raised one clock early so they sit on the final stop clock.
          if (w_last_stop && w_pre_tick) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
          if (w_bit_tick) begin
            if (!w_last_stop) begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else if (w_accept) begin
              r_state   <= START;
              r_shift   <= data;
              r_bit_cnt <= {BIT_W{1'b0}};
              r_txd     <= 1'b0;
              r_ready   <= 1'b0;
              r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
              r_parity  <= f_parity(data);
`endif
            end else begin
              r_state   <= IDLE;
              r_bit_cnt <= {BIT_W{1'b0}};
              r_txd     <= 1'b1;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bit_cnt <= {BIT_W{1'b0}};
          r_txd     <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign TxD   = r_txd;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (three parameter sets, CLKS_PER_BIT=4).
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] valid_v;
  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  wire  [2:0] w_ready;
  wire  [2:0] w_txd;
  wire  [2:0] w_busy;
  wire  [2:0] w_done;

  int n_cmp;
  int n_err;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .tick(clk), .rst(rst_n), .data(data0), .valid(valid_v[0]),
    .ready(w_ready[0]), .TxD(w_txd[0]), .busy(w_busy[0]), .done(w_done[0]));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .tick(clk), .rst(rst_n), .data(data1), .valid(valid_v[1]),
    .ready(w_ready[1]), .TxD(w_txd[1]), .busy(w_busy[1]), .done(w_done[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .tick(clk), .rst(rst_n), .data(data2), .valid(valid_v[2]),
    .ready(w_ready[2]), .TxD(w_txd[2]), .busy(w_busy[2]), .done(w_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int u, input logic [7:0] d);
    case (u)
      0:       data0 = d;
      1:       data1 = d[6:0];
      default: data2 = d;
    endcase
  endtask

  // Present d at a negedge, let the handshake edge pass, leave at negedge of frame cycle 1.
  task automatic start_frame(input int u, input logic [7:0] d, input logic hold, input string tag);
    @(negedge clk);
    check_eq($sformatf("%s_pre_ready", tag), {31'd0, w_ready[u]}, 32'd1);
    set_data(u, d);
    valid_v[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid_v[u] = 1'b0;
  endtask

  // Checks frame cycles 1..nbits*CPB; returns at negedge of the last frame cycle.
  task automatic watch_frame(input int u, input logic [11:0] exp_bits, input int nbits, input string tag);
    int last;
    last = nbits * CPB;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(negedge clk);
      check_eq($sformatf("%s_txd_c%0d", tag, k), {31'd0, w_txd[u]}, {31'd0, exp_bits[(k-1)/CPB]});
      check_eq($sformatf("%s_ready_c%0d", tag, k), {31'd0, w_ready[u]}, (k == last) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s_done_c%0d", tag, k), {31'd0, w_done[u]}, (k == last) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s_busy_c%0d", tag, k), {31'd0, w_busy[u]}, 32'd1);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check_eq($sformatf("%s_idle_txd", tag), {31'd0, w_txd[u]}, 32'd1);
    check_eq($sformatf("%s_idle_ready", tag), {31'd0, w_ready[u]}, 32'd1);
    check_eq($sformatf("%s_idle_busy", tag), {31'd0, w_busy[u]}, 32'd0);
    check_eq($sformatf("%s_idle_done", tag), {31'd0, w_done[u]}, 32'd0);
  endtask

  initial begin
    logic [11:0] e_a5, e_07_even, e_07_odd, e_55, e_0f, e_7f, e_3c;
    int n_txd1, n_rdy1, n_busy0, n_done;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    valid_v = 3'b000;
    data0 = 8'h00;
    data1 = 7'h00;
    data2 = 8'h00;

    // Frame bits LSB first: bit 0 = start, then data LSB first, [parity], stop(s).
`ifdef UART_TX_PARITY_EN
    e_a5      = 12'b0_1_0_10100101_0;
    e_07_even = 12'b0_1_1_00000111_0;
    e_07_odd  = 12'b0_1_0_00000111_0;
    e_55      = 12'b0_1_0_01010101_0;
    e_0f      = 12'b0_1_0_00001111_0;
    e_7f      = 12'b0_1_1_1_1111111_0;
    e_3c      = 12'b0_1_0_00111100_0;
`else
    e_a5      = 12'b00_1_10100101_0;
    e_07_even = 12'b00_1_00000111_0;
    e_07_odd  = 12'b00_1_00000111_0;
    e_55      = 12'b00_1_01010101_0;
    e_0f      = 12'b00_1_00001111_0;
    e_7f      = 12'b00_1_1_1111111_0;
    e_3c      = 12'b00_1_00111100_0;
`endif

    @(negedge clk);
    for (int u = 0; u < 3; u++) check_idle(u, $sformatf("rst%0d", u));
    @(negedge clk);
    rst_n = 1'b1;

    n_txd1 = 0; n_rdy1 = 0; n_busy0 = 0; n_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (w_txd[0] === 1'b1) n_txd1++;
      if (w_ready[0] === 1'b1) n_rdy1++;
      if (w_busy[0] === 1'b0) n_busy0++;
      if (w_done !== 3'b000) n_done++;
    end
    check_eq("idle100_txd_high", n_txd1, 32'd100);
    check_eq("idle100_ready_high", n_rdy1, 32'd100);
    check_eq("idle100_busy_low", n_busy0, 32'd100);
    check_eq("idle100_no_done", n_done, 32'd0);

    start_frame(0, 8'hA5, 1'b0, "a5");
    watch_frame(0, e_a5, NB, "a5");
    @(negedge clk);
    check_idle(0, "a5_after");

    start_frame(0, 8'h07, 1'b0, "p07e");
    watch_frame(0, e_07_even, NB, "p07e");
    @(negedge clk);
    check_idle(0, "p07e_after");

    start_frame(2, 8'h07, 1'b0, "p07o");
    watch_frame(2, e_07_odd, NB, "p07o");
    @(negedge clk);
    check_idle(2, "p07o_after");

    // Back-to-back: valid stays high throughout, new data presented while ready is low.
    start_frame(0, 8'h55, 1'b1, "b2b55");
    data0 = 8'h0F;
    watch_frame(0, e_55, NB, "b2b55");
    @(negedge clk);
    valid_v[0] = 1'b0;
    watch_frame(0, e_0f, NB, "b2b0f");
    @(negedge clk);
    check_idle(0, "b2b_after");

    start_frame(1, 8'h7F, 1'b0, "s2d7");
    watch_frame(1, e_7f, NB, "s2d7");
    @(negedge clk);
    check_idle(1, "s2d7_after");

    // Abort in the middle of data bit 3 (frame cycles 17..20).
    start_frame(0, 8'h00, 1'b0, "abort");
    repeat (17) @(negedge clk);
    check_eq("abort_pre_txd", {31'd0, w_txd[0]}, 32'd0);
    check_eq("abort_pre_busy", {31'd0, w_busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_txd", {31'd0, w_txd[0]}, 32'd1);
    check_eq("abort_busy", {31'd0, w_busy[0]}, 32'd0);
    check_eq("abort_ready", {31'd0, w_ready[0]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "abort_rel");

    start_frame(0, 8'h3C, 1'b0, "r3c");
    watch_frame(0, e_3c, NB, "r3c");
    @(negedge clk);
    check_idle(0, "r3c_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
